// File: rtl/idu_stage_if.sv
// Fetch-side and execute-side handshake bundle of the instruction decode stage.
// The slave modport is the decoder's view; master is the surrounding pipeline.
interface idu_stage_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [4:0]      out_rd;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic [2:0]      out_ext_type;
   logic [2:0]      out_reg_write;
   logic [1:0]      out_pc_src;
   logic [4:0]      out_alu_ctrl;
   logic            out_mem_rd;
   logic            out_mem_wr;
   logic            out_illegal;
   logic            out_ebreak;

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
             out_ext_type, out_reg_write, out_pc_src, out_alu_ctrl,
             out_mem_rd, out_mem_wr, out_illegal, out_ebreak
   );

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
             out_ext_type, out_reg_write, out_pc_src, out_alu_ctrl,
             out_mem_rd, out_mem_wr, out_illegal, out_ebreak
   );
endinterface

// File: rtl/idu_stage.sv
// RISC-V instruction decode stage with a one-deep registered output and trap halt.
// Optional macro IDU_STAGE_TRAP_EN enables the HALT state on illegal/EBREAK acceptance.
module idu_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   idu_stage_if.slave       bus,
   input  logic             resume,
   output logic             halted,
   output logic [CNT_W-1:0] decode_cnt
);

   localparam bit IS_RV32 = (XLEN == 32);

   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_OP32    = 7'b0111011;
   localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
   localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

   localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

   localparam logic [2:0] EXT_NONE = 3'd0;
   localparam logic [2:0] EXT_I    = 3'd1;
   localparam logic [2:0] EXT_S    = 3'd2;
   localparam logic [2:0] EXT_B    = 3'd3;
   localparam logic [2:0] EXT_U    = 3'd4;
   localparam logic [2:0] EXT_J    = 3'd5;

   localparam logic [2:0] WB_NONE = 3'd0;
   localparam logic [2:0] WB_ALU  = 3'd1;
   localparam logic [2:0] WB_LOAD = 3'd2;
   localparam logic [2:0] WB_PC4  = 3'd3;
   localparam logic [2:0] WB_IMM  = 3'd4;

   localparam logic [1:0] PCS_SEQ  = 2'd0;
   localparam logic [1:0] PCS_JAL  = 2'd1;
   localparam logic [1:0] PCS_JALR = 2'd2;
   localparam logic [1:0] PCS_BR   = 2'd3;

   typedef struct packed {
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [2:0] ext_type;
      logic [2:0] reg_write;
      logic [1:0] pc_src;
      logic [4:0] alu_ctrl;
      logic       mem_rd;
      logic       mem_wr;
      logic       illegal;
      logic       ebreak;
   } dec_t;

   localparam dec_t DEC_ZERO = dec_t'({$bits(dec_t){1'b0}});

   // Pure combinational decode of one instruction word into the control bundle.
   function automatic dec_t decode(input logic [31:0] instr);
      dec_t       d;
      logic [2:0] f3;
      logic       is_shift;
      logic       funct6_ok;
      d         = DEC_ZERO;
      f3        = instr[14:12];
      is_shift  = (f3 == 3'b001) || (f3 == 3'b101);
      funct6_ok = (instr[31:26] == 6'b000000) || (instr[31:26] == 6'b010000);
      d.rd      = instr[11:7];
      d.rs1     = instr[19:15];
      d.ebreak  = (instr == INSTR_EBREAK);
      case (instr[6:0])
         OPC_LUI: begin
            d.rs1       = 5'd0;
            d.ext_type  = EXT_U;
            d.reg_write = WB_IMM;
         end
         OPC_AUIPC: begin
            d.rs1       = 5'd0;
            d.ext_type  = EXT_U;
            d.reg_write = WB_ALU;
            d.alu_ctrl  = 5'b10000;
         end
         OPC_JAL: begin
            d.rs1       = 5'd0;
            d.ext_type  = EXT_J;
            d.reg_write = WB_PC4;
            d.pc_src    = PCS_JAL;
         end
         OPC_JALR: begin
            d.ext_type  = EXT_I;
            d.reg_write = WB_PC4;
            d.pc_src    = PCS_JALR;
            d.alu_ctrl  = 5'b10000;
         end
         OPC_BRANCH: begin
            d.rd       = 5'd0;
            d.rs2      = instr[24:20];
            d.ext_type = EXT_B;
            d.pc_src   = PCS_BR;
            d.alu_ctrl = {2'b00, f3};
         end
         OPC_LOAD: begin
            d.ext_type  = EXT_I;
            d.reg_write = WB_LOAD;
            d.alu_ctrl  = 5'b10000;
            d.mem_rd    = 1'b1;
         end
         OPC_STORE: begin
            d.rd       = 5'd0;
            d.rs2      = instr[24:20];
            d.ext_type = EXT_S;
            d.alu_ctrl = 5'b10000;
            d.mem_wr   = 1'b1;
         end
         OPC_OPIMM: begin
            d.ext_type  = EXT_I;
            d.reg_write = WB_ALU;
            d.alu_ctrl  = {1'b0, ((f3 == 3'b101) ? instr[30] : 1'b0), f3};
            // bit 25 is shamt[5], which only exists on RV64
            d.illegal   = is_shift && ((IS_RV32 && instr[25]) || !funct6_ok);
         end
         OPC_OP: begin
            d.rs2       = instr[24:20];
            d.ext_type  = EXT_NONE;
            d.reg_write = WB_ALU;
            d.alu_ctrl  = {1'b0, instr[30], f3};
         end
         OPC_OP32: begin
            d.rs2       = instr[24:20];
            d.ext_type  = EXT_NONE;
            d.reg_write = WB_ALU;
            d.illegal   = IS_RV32;
         end
         OPC_OPIMM32: begin
            d.ext_type  = EXT_I;
            d.reg_write = WB_ALU;
            d.illegal   = IS_RV32 || (is_shift && !funct6_ok);
         end
         OPC_SYSTEM: begin
            d.ext_type = EXT_I;
            d.illegal  = (instr != INSTR_ECALL) && (instr != INSTR_EBREAK);
         end
         default: begin
            d.illegal = 1'b1;
         end
      endcase
      return d;
   endfunction

   dec_t             dec_s;
   dec_t             dec_r;
   logic             out_valid_r;
   logic [XLEN-1:0]  out_pc_r;
   logic [CNT_W-1:0] cnt_r;
   logic             run_s;
   logic             in_ready_s;
   logic             accept_s;

   assign dec_s      = decode(bus.in_instr);
   assign in_ready_s = rst_n && run_s && (!out_valid_r || bus.out_ready);
   assign accept_s   = bus.in_valid && in_ready_s;

`ifdef IDU_STAGE_TRAP_EN
   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t state_r;
   state_t state_nxt_s;

   // Trap state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_RUN;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Halt on accepting a trapping word; only resume leaves HALT.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_RUN: begin
            if (accept_s && (dec_s.illegal || dec_s.ebreak)) begin
               state_nxt_s = ST_HALT;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_HALT: begin
            if (resume) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_HALT;
            end
         end
         default: begin
            state_nxt_s = ST_RUN;
         end
      endcase
   end

   assign run_s  = (state_r == ST_RUN);
   assign halted = (state_r == ST_HALT);
`else
   logic unused_resume_s;

   assign unused_resume_s = resume;
   assign run_s           = 1'b1;
   assign halted          = 1'b0;
`endif

   // Output register: load on acceptance, drop valid once drained; fields hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_pc_r    <= {XLEN{1'b0}};
         dec_r       <= DEC_ZERO;
      end else if (accept_s) begin
         out_valid_r <= 1'b1;
         out_pc_r    <= bus.in_pc;
         dec_r       <= dec_s;
      end else if (bus.out_ready) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   // Accepted-instruction counter, wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (accept_s) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign bus.in_ready      = in_ready_s;
   assign bus.out_valid     = out_valid_r;
   assign bus.out_pc        = out_pc_r;
   assign bus.out_rd        = dec_r.rd;
   assign bus.out_rs1       = dec_r.rs1;
   assign bus.out_rs2       = dec_r.rs2;
   assign bus.out_ext_type  = dec_r.ext_type;
   assign bus.out_reg_write = dec_r.reg_write;
   assign bus.out_pc_src    = dec_r.pc_src;
   assign bus.out_alu_ctrl  = dec_r.alu_ctrl;
   assign bus.out_mem_rd    = dec_r.mem_rd;
   assign bus.out_mem_wr    = dec_r.mem_wr;
   assign bus.out_illegal   = dec_r.illegal;
   assign bus.out_ebreak    = dec_r.ebreak;
   assign decode_cnt        = cnt_r;

endmodule

// File: tb/tb_idu_stage.sv
// Self-checking bench for idu_stage: RV32 instance (4-bit counter) plus an RV64 instance.
// Compares against a rule-level decode model and a cycle-level handshake model.
module tb_idu_stage;

`ifdef IDU_STAGE_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   typedef enum int {K_LUI, K_AUIPC, K_JAL, K_JALR, K_BR, K_LD, K_ST,
                     K_OPI, K_OP, K_OP32, K_OPI32, K_SYS, K_BAD} kind_t;

   typedef struct packed {
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [2:0] ext;
      logic [2:0] rw;
      logic [1:0] pcs;
      logic [4:0] alu;
      logic       mrd;
      logic       mwr;
      logic       ill;
      logic       ebk;
   } fld_t;

   typedef struct packed {
      logic        valid;
      logic        halted;
      logic [3:0]  cnt;
      logic [31:0] pc;
      fld_t        f;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        resume32 = 1'b0;
   logic        resume64 = 1'b0;
   logic        halted32;
   logic        halted64;
   logic [3:0]  cnt32;
   logic [31:0] cnt64;

   int checks = 0;
   int errors = 0;

   // reference model state for the RV32 instance
   logic        m_ov;
   logic        m_halt;
   int          m_cnt;
   logic [31:0] m_pc;
   fld_t        m_f;

   idu_stage_if #(.XLEN(32)) b32 ();
   idu_stage_if #(.XLEN(64)) b64 ();

   idu_stage #(.XLEN(32), .CNT_W(4)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .bus(b32), .resume(resume32),
      .halted(halted32), .decode_cnt(cnt32)
   );

   idu_stage #(.XLEN(64), .CNT_W(32)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .bus(b64), .resume(resume64),
      .halted(halted64), .decode_cnt(cnt64)
   );

   always #5 clk = ~clk;

   function automatic kind_t kind_of(input logic [31:0] w);
      case (w[6:0])
         7'b0110111: return K_LUI;
         7'b0010111: return K_AUIPC;
         7'b1101111: return K_JAL;
         7'b1100111: return K_JALR;
         7'b1100011: return K_BR;
         7'b0000011: return K_LD;
         7'b0100011: return K_ST;
         7'b0010011: return K_OPI;
         7'b0110011: return K_OP;
         7'b0111011: return K_OP32;
         7'b0011011: return K_OPI32;
         7'b1110011: return K_SYS;
         default:    return K_BAD;
      endcase
   endfunction

   // Decode rules written per field, straight from the field definitions.
   function automatic fld_t ref_decode(input logic [31:0] w, input int xlen);
      fld_t       f;
      kind_t      k;
      logic [2:0] f3;
      logic       shift;
      k     = kind_of(w);
      f3    = w[14:12];
      shift = (k == K_OPI || k == K_OPI32) && (f3 == 3'd1 || f3 == 3'd5);
      f.rs1 = (k inside {K_LUI, K_AUIPC, K_JAL}) ? 5'd0 : w[19:15];
      f.rd  = (k inside {K_BR, K_ST}) ? 5'd0 : w[11:7];
      f.rs2 = (k inside {K_BR, K_ST, K_OP, K_OP32}) ? w[24:20] : 5'd0;
      case (k)
         K_OPI, K_OPI32, K_LD, K_JALR, K_SYS: f.ext = 3'd1;
         K_ST:         f.ext = 3'd2;
         K_BR:         f.ext = 3'd3;
         K_LUI, K_AUIPC: f.ext = 3'd4;
         K_JAL:        f.ext = 3'd5;
         default:      f.ext = 3'd0;
      endcase
      case (k)
         K_OP, K_OPI, K_OP32, K_OPI32, K_AUIPC: f.rw = 3'd1;
         K_LD:         f.rw = 3'd2;
         K_JAL, K_JALR: f.rw = 3'd3;
         K_LUI:        f.rw = 3'd4;
         default:      f.rw = 3'd0;
      endcase
      f.pcs = (k == K_JAL) ? 2'd1 : (k == K_JALR) ? 2'd2 : (k == K_BR) ? 2'd3 : 2'd0;
      f.alu[2:0] = (k inside {K_OP, K_OPI, K_BR}) ? f3 : 3'd0;
      f.alu[3]   = (k == K_OP || (k == K_OPI && f3 == 3'd5)) ? w[30] : 1'b0;
      f.alu[4]   = (k inside {K_LD, K_ST, K_AUIPC, K_JALR});
      f.mrd = (k == K_LD);
      f.mwr = (k == K_ST);
      f.ebk = (w == 32'h0010_0073);
      f.ill = (k == K_BAD)
           || (xlen == 32 && (k == K_OP32 || k == K_OPI32))
           || (shift && xlen == 32 && w[25])
           || (shift && !(w[31:26] == 6'b000000 || w[31:26] == 6'b010000))
           || (k == K_SYS && w != 32'h0000_0073 && w != 32'h0010_0073);
      return f;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 12))
         0:  w[6:0] = 7'b0110111;
         1:  w[6:0] = 7'b0010111;
         2:  w[6:0] = 7'b1101111;
         3:  w[6:0] = 7'b1100111;
         4:  w[6:0] = 7'b1100011;
         5:  w[6:0] = 7'b0000011;
         6:  w[6:0] = 7'b0100011;
         7: begin
            w[6:0] = 7'b0010011;
            if ($urandom_range(0, 1) == 1) begin
               w[14:12] = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'b101;
               w[31:26] = ($urandom_range(0, 1) == 1) ? 6'b000000 : 6'b010000;
            end
         end
         8:  w[6:0] = 7'b0110011;
         9:  w[6:0] = 7'b0111011;
         10: w[6:0] = 7'b0011011;
         11: begin
            case ($urandom_range(0, 2))
               0:       w = 32'h0000_0073;
               1:       w = 32'h0010_0073;
               default: w[6:0] = 7'b1110011;
            endcase
         end
         default: ;
      endcase
      return w;
   endfunction

   function automatic logic m_ready();
      return rst_n && !m_halt && (!m_ov || b32.out_ready);
   endfunction

   function automatic obs_t exp32();
      obs_t e;
      e.valid  = m_ov;
      e.halted = m_halt;
      e.cnt    = m_cnt[3:0];
      e.pc     = m_pc;
      e.f      = m_f;
      return e;
   endfunction

   function automatic obs_t obs32();
      obs_t o;
      o.valid  = b32.out_valid;
      o.halted = halted32;
      o.cnt    = cnt32;
      o.pc     = b32.out_pc;
      o.f      = '{b32.out_rd, b32.out_rs1, b32.out_rs2, b32.out_ext_type,
                   b32.out_reg_write, b32.out_pc_src, b32.out_alu_ctrl,
                   b32.out_mem_rd, b32.out_mem_wr, b32.out_illegal, b32.out_ebreak};
      return o;
   endfunction

   function automatic fld_t obs64();
      return '{b64.out_rd, b64.out_rs1, b64.out_rs2, b64.out_ext_type,
               b64.out_reg_write, b64.out_pc_src, b64.out_alu_ctrl,
               b64.out_mem_rd, b64.out_mem_wr, b64.out_illegal, b64.out_ebreak};
   endfunction

   task automatic model_reset();
      m_ov = 1'b0; m_halt = 1'b0; m_cnt = 0; m_pc = 32'd0; m_f = '0;
   endtask

   // call at a falling edge
   task automatic drive32(input logic v, input logic [31:0] w, input logic [31:0] pc,
                          input logic rdy, input logic res);
      b32.in_valid = v; b32.in_instr = w; b32.in_pc = pc; b32.out_ready = rdy;
      resume32 = res;
      #1;
   endtask

   task automatic tick32();
      logic acc;
      fld_t nf;
      acc = b32.in_valid && m_ready();
      nf  = ref_decode(b32.in_instr, 32);
      if (m_halt) m_halt = !resume32;
      else        m_halt = TRAP_EN && acc && (nf.ill || nf.ebk);
      if (acc) begin
         m_ov = 1'b1; m_f = nf; m_pc = b32.in_pc; m_cnt = (m_cnt + 1) % 16;
      end else if (b32.out_ready) begin
         m_ov = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      drive32(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      model_reset();
      @(negedge clk);
      #1;
      checks++;
      if (obs32() !== exp32() || b32.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got=%h rdy=%b exp=%h rdy=0", obs32(), b32.in_ready, exp32());
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (b32.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready got=%b exp=1", b32.in_ready);
      end
   endtask

   task automatic test_addi();
      drive32(1'b1, 32'h0050_0093, 32'h0000_1000, 1'b1, 1'b0);
      tick32();
      checks++;
      if ({b32.out_valid, b32.out_rd, b32.out_rs1, b32.out_rs2, b32.out_ext_type,
           b32.out_reg_write, b32.out_alu_ctrl, cnt32}
          !== {1'b1, 5'd1, 5'd0, 5'd0, 3'd1, 3'd1, 5'd0, 4'd1}) begin
         errors++;
         $display("FAIL addi_fields got=%h exp=%h", obs32(), exp32());
      end
      checks++;
      if (obs32() !== exp32()) begin
         errors++;
         $display("FAIL addi_model got=%h exp=%h", obs32(), exp32());
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive32(1'b1, 32'h0020_A423, 32'h0000_0200, 1'b1, 1'b0);
      tick32();
      for (int i = 0; i < 2; i++) begin
         drive32(1'b1, 32'h0020_8863, 32'h0000_0204, 1'b0, 1'b0);
         checks++;
         if (b32.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stall_ready got=%b exp=0", b32.in_ready);
         end
         tick32();
         checks++;
         if (obs32() !== exp32() || b32.out_pc !== 32'h0000_0200 || b32.out_mem_wr !== 1'b1) begin
            errors++;
            $display("FAIL b2b_sw_held got=%h exp=%h", obs32(), exp32());
         end
      end
      drive32(1'b1, 32'h0020_8863, 32'h0000_0204, 1'b1, 1'b0);
      checks++;
      if (b32.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_drain_ready got=%b exp=1", b32.in_ready);
      end
      tick32();
      checks++;
      if ({b32.out_valid, b32.out_rd, b32.out_pc_src, b32.out_ext_type, b32.out_pc}
          !== {1'b1, 5'd0, 2'd3, 3'd3, 32'h0000_0204} || obs32() !== exp32()) begin
         errors++;
         $display("FAIL b2b_beq got=%h exp=%h", obs32(), exp32());
      end
   endtask

   task automatic test_slli_xlen();
      logic [63:0] pc64;
      do_reset();
      pc64 = {$urandom, $urandom};
      drive32(1'b1, 32'h0200_1093, 32'h0000_0300, 1'b1, 1'b0);
      b64.in_valid = 1'b1; b64.in_instr = 32'h0200_1093; b64.in_pc = pc64; b64.out_ready = 1'b1;
      tick32();
      checks++;
      if (b32.out_illegal !== 1'b1 || halted32 !== TRAP_EN || obs32() !== exp32()) begin
         errors++;
         $display("FAIL slli_rv32 got=%h exp=%h", obs32(), exp32());
      end
      checks++;
      if (b64.out_illegal !== 1'b0 || b64.out_valid !== 1'b1 || b64.out_pc !== pc64
          || obs64() !== ref_decode(32'h0200_1093, 64)) begin
         errors++;
         $display("FAIL slli_rv64 got=%h exp=%h", obs64(), ref_decode(32'h0200_1093, 64));
      end
      drive32(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      b64.in_instr = 32'h0400_1093;
      checks++;
      if (b32.in_ready !== !TRAP_EN) begin
         errors++;
         $display("FAIL slli_halt_ready got=%b exp=%b", b32.in_ready, !TRAP_EN);
      end
      tick32();
      b64.in_valid = 1'b0;
      checks++;
      if (b64.out_illegal !== 1'b1 || halted64 !== TRAP_EN || cnt64 !== 32'd2) begin
         errors++;
         $display("FAIL funct6_rv64 got=%b/%b/%0d exp=1/%b/2", b64.out_illegal, halted64, cnt64, TRAP_EN);
      end
      drive32(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
      tick32();
   endtask

   task automatic test_ebreak_resume();
      do_reset();
      drive32(1'b1, 32'h0010_0073, 32'h0000_0400, 1'b1, 1'b0);
      tick32();
      checks++;
      if (b32.out_ebreak !== 1'b1 || halted32 !== TRAP_EN || obs32() !== exp32()) begin
         errors++;
         $display("FAIL ebreak_accept got=%h exp=%h", obs32(), exp32());
      end
      for (int i = 0; i < 3; i++) begin
         drive32(1'b1, 32'h0050_0093, 32'h0000_0404 + 32'(4 * i), 1'b1, 1'b0);
         checks++;
         if (b32.in_ready !== !TRAP_EN) begin
            errors++;
            $display("FAIL ebreak_hold_ready got=%b exp=%b", b32.in_ready, !TRAP_EN);
         end
         tick32();
         checks++;
         if (obs32() !== exp32()) begin
            errors++;
            $display("FAIL ebreak_hold got=%h exp=%h", obs32(), exp32());
         end
      end
      drive32(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
      tick32();
      checks++;
      if (halted32 !== 1'b0 || obs32() !== exp32()) begin
         errors++;
         $display("FAIL resume_exit got=%h exp=%h", obs32(), exp32());
      end
      drive32(1'b1, 32'h0050_0093, 32'h0000_0500, 1'b1, 1'b0);
      checks++;
      if (b32.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL resume_ready got=%b exp=1", b32.in_ready);
      end
      tick32();
      checks++;
      if (b32.out_valid !== 1'b1 || obs32() !== exp32()) begin
         errors++;
         $display("FAIL resume_accept got=%h exp=%h", obs32(), exp32());
      end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 16; i++) begin
         drive32(1'b1, 32'h0000_0013 | ({27'd0, 5'(i)} << 7), 32'(i * 4), 1'b1, 1'b0);
         tick32();
      end
      checks++;
      if (cnt32 !== 4'd0 || obs32() !== exp32()) begin
         errors++;
         $display("FAIL cnt_wrap got=%h exp=%h", obs32(), exp32());
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive32(($urandom_range(0, 3) != 0), rand_instr(), $urandom,
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0));
         checks++;
         if (b32.in_ready !== m_ready()) begin
            errors++;
            $display("FAIL rand_ready i=%0d got=%b exp=%b", i, b32.in_ready, m_ready());
         end
         tick32();
         checks++;
         if (obs32() !== exp32()) begin
            errors++;
            $display("FAIL rand_out i=%0d got=%h exp=%h", i, obs32(), exp32());
         end
      end
   endtask

   task automatic test_reset_mid_handshake();
      do_reset();
      drive32(1'b1, 32'h0020_A423, 32'h0000_0600, 1'b1, 1'b0);
      tick32();
      drive32(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      tick32();
      checks++;
      if (b32.out_valid !== 1'b1 || obs32() !== exp32()) begin
         errors++;
         $display("FAIL mid_pre got=%h exp=%h", obs32(), exp32());
      end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (b32.out_valid !== 1'b0 || cnt32 !== 4'd0 || b32.in_ready !== 1'b0 || obs32() !== exp32()) begin
         errors++;
         $display("FAIL mid_reset got=%h rdy=%b exp=%h rdy=0", obs32(), b32.in_ready, exp32());
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      b32.in_valid = 1'b0; b32.in_instr = 32'd0; b32.in_pc = 32'd0; b32.out_ready = 1'b0;
      b64.in_valid = 1'b0; b64.in_instr = 32'd0; b64.in_pc = 64'd0; b64.out_ready = 1'b0;
      test_reset();
      test_addi();
      test_back_to_back();
      test_slli_xlen();
      test_ebreak_resume();
      test_wrap();
      test_random();
      test_reset_mid_handshake();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
